// File: rtl/cab_prog_sequencer.sv
// cab_prog_sequencer
// Sequences floating-gate programming of one switch-matrix element inside an
// island's CAB row: select the element, let the select lines settle, then
// alternate program pulses with read-back verifies until the measured value
// reaches the target, the iteration budget runs out, or the command is aborted.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only when idle)
//   cmd_cab/row/col               element address
//   cmd_target                    verify threshold (pass when meas_val >= target)
//   cmd_pulse_len                 pulse width in cycles, 0 behaves as 1
//   abort                         terminate the running command
//   cab_sel/row_sel/col_sel       one-hot CAB select and matrix address
//   sel_en                        address/select valid
//   prog_pulse                    injection pulse
//   meas_en, meas_valid, meas_val read-back request and result
//   rsp_valid/rsp_ready           response handshake
//   rsp_status                    00 ok, 01 timeout, 10 bad address, 11 aborted
//   rsp_iters                     number of pulses applied
//   busy                          any state other than idle
//
// Every output is a flop whose D input is decoded from the next state, so the
// outputs always agree with the state register and carry no combinational path
// from the inputs.
module cab_prog_sequencer #(
    parameter int NUM_CAB  = 7,
    parameter int MROWS    = 7,
    parameter int MCOLS    = 1,
    parameter int PULSE_W  = 8,
    parameter int MEAS_W   = 10,
    parameter int MAX_ITER = 15,
    parameter int SETTLE   = 4,
    parameter int GAP      = 2,
    localparam int CAB_W   = (NUM_CAB > 1) ? $clog2(NUM_CAB) : 1,
    localparam int ROW_W   = (MROWS > 1) ? $clog2(MROWS) : 1,
    localparam int COL_W   = (MCOLS > 1) ? $clog2(MCOLS) : 1,
    localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CAB_W-1:0]   cmd_cab,
    input  logic [ROW_W-1:0]   cmd_row,
    input  logic [COL_W-1:0]   cmd_col,
    input  logic [MEAS_W-1:0]  cmd_target,
    input  logic [PULSE_W-1:0] cmd_pulse_len,
    input  logic               abort,
    output logic [NUM_CAB-1:0] cab_sel,
    output logic [ROW_W-1:0]   row_sel,
    output logic [COL_W-1:0]   col_sel,
    output logic               sel_en,
    output logic               prog_pulse,
    output logic               meas_en,
    input  logic               meas_valid,
    input  logic [MEAS_W-1:0]  meas_val,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [ITER_W-1:0]  rsp_iters,
    output logic               busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_PULSE  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_VERIFY = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    localparam logic [1:0] RS_OK      = 2'b00;
    localparam logic [1:0] RS_TIMEOUT = 2'b01;
    localparam logic [1:0] RS_BADADDR = 2'b10;
    localparam logic [1:0] RS_ABORT   = 2'b11;

    logic [2:0]         state_r,  state_s;
    logic [PULSE_W-1:0] cnt_r,    cnt_s;
    logic [ITER_W-1:0]  iter_r,   iter_s;
    logic [1:0]         status_r, status_s;
    logic [CAB_W-1:0]   cab_r,    cab_s;
    logic [ROW_W-1:0]   row_r,    row_s;
    logic [COL_W-1:0]   col_r,    col_s;
    logic [MEAS_W-1:0]  target_r, target_s;
    logic [PULSE_W-1:0] len_r,    len_s;
    logic               bad_addr_s;
    logic [PULSE_W-1:0] pulse_load_s;
    logic               sel_on_s;

    // Address range check on the incoming command, widened so it never wraps.
    always_comb begin
        bad_addr_s = (32'(cmd_cab) >= 32'(NUM_CAB)) ||
                     (32'(cmd_row) >= 32'(MROWS))   ||
                     (32'(cmd_col) >= 32'(MCOLS));
    end

    // Down-counter load for a pulse; a zero length still yields one cycle.
    always_comb begin
        if (len_r == {PULSE_W{1'b0}}) begin
            pulse_load_s = {PULSE_W{1'b0}};
        end else begin
            pulse_load_s = len_r - {{(PULSE_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state, phase counter, iteration count and command field capture.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        iter_s   = iter_r;
        status_s = status_r;
        cab_s    = cab_r;
        row_s    = row_r;
        col_s    = col_r;
        target_s = target_r;
        len_s    = len_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cab_s    = cmd_cab;
                    row_s    = cmd_row;
                    col_s    = cmd_col;
                    target_s = cmd_target;
                    len_s    = cmd_pulse_len;
                    iter_s   = {ITER_W{1'b0}};
                    if (bad_addr_s) begin
                        state_s  = ST_RESP;
                        status_s = RS_BADADDR;
                    end else begin
                        state_s = ST_SELECT;
                        cnt_s   = PULSE_W'(SETTLE - 1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_s  = ST_RESP;
                    status_s = RS_ABORT;
                end else if (cnt_r == {PULSE_W{1'b0}}) begin
                    state_s = ST_PULSE;
                    cnt_s   = pulse_load_s;
                    iter_s  = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_s = cnt_r - {{(PULSE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_s  = ST_RESP;
                    status_s = RS_ABORT;
                end else if (cnt_r == {PULSE_W{1'b0}}) begin
                    state_s = ST_GAP;
                    cnt_s   = PULSE_W'(GAP - 1);
                end else begin
                    cnt_s = cnt_r - {{(PULSE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_s  = ST_RESP;
                    status_s = RS_ABORT;
                end else if (cnt_r == {PULSE_W{1'b0}}) begin
                    state_s = ST_VERIFY;
                end else begin
                    cnt_s = cnt_r - {{(PULSE_W-1){1'b0}}, 1'b1};
                end
            end
            ST_VERIFY: begin
                // abort takes priority over a result arriving in the same cycle
                if (abort) begin
                    state_s  = ST_RESP;
                    status_s = RS_ABORT;
                end else if (meas_valid) begin
                    if (meas_val >= target_r) begin
                        state_s  = ST_RESP;
                        status_s = RS_OK;
                    end else if (iter_r == ITER_W'(MAX_ITER)) begin
                        state_s  = ST_RESP;
                        status_s = RS_TIMEOUT;
                    end else begin
                        state_s = ST_PULSE;
                        cnt_s   = pulse_load_s;
                        iter_s  = iter_r + {{(ITER_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_VERIFY;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Select lines are driven only while an element is being worked on.
    always_comb begin
        sel_on_s = (state_s == ST_SELECT) || (state_s == ST_PULSE) ||
                   (state_s == ST_GAP)    || (state_s == ST_VERIFY);
    end

    // State, working registers and output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {PULSE_W{1'b0}};
            iter_r     <= {ITER_W{1'b0}};
            status_r   <= 2'b00;
            cab_r      <= {CAB_W{1'b0}};
            row_r      <= {ROW_W{1'b0}};
            col_r      <= {COL_W{1'b0}};
            target_r   <= {MEAS_W{1'b0}};
            len_r      <= {PULSE_W{1'b0}};
            cmd_ready  <= 1'b1;
            cab_sel    <= {NUM_CAB{1'b0}};
            row_sel    <= {ROW_W{1'b0}};
            col_sel    <= {COL_W{1'b0}};
            sel_en     <= 1'b0;
            prog_pulse <= 1'b0;
            meas_en    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'b00;
            rsp_iters  <= {ITER_W{1'b0}};
            busy       <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            iter_r     <= iter_s;
            status_r   <= status_s;
            cab_r      <= cab_s;
            row_r      <= row_s;
            col_r      <= col_s;
            target_r   <= target_s;
            len_r      <= len_s;
            cmd_ready  <= (state_s == ST_IDLE);
            cab_sel    <= sel_on_s ? ({{(NUM_CAB-1){1'b0}}, 1'b1} << cab_s) : {NUM_CAB{1'b0}};
            row_sel    <= sel_on_s ? row_s : {ROW_W{1'b0}};
            col_sel    <= sel_on_s ? col_s : {COL_W{1'b0}};
            sel_en     <= sel_on_s;
            prog_pulse <= (state_s == ST_PULSE);
            meas_en    <= (state_s == ST_VERIFY);
            rsp_valid  <= (state_s == ST_RESP);
            rsp_status <= (state_s == ST_RESP) ? status_s : 2'b00;
            rsp_iters  <= (state_s == ST_RESP) ? iter_s : {ITER_W{1'b0}};
            busy       <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_cab_prog_sequencer.sv
// Directed testbench for cab_prog_sequencer with default parameters.
module tb_cab_prog_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_cab;
    logic [2:0] cmd_row;
    logic [0:0] cmd_col;
    logic [9:0] cmd_target;
    logic [7:0] cmd_pulse_len;
    logic       abort;
    logic [6:0] cab_sel;
    logic [2:0] row_sel;
    logic [0:0] col_sel;
    logic       sel_en;
    logic       prog_pulse;
    logic       meas_en;
    logic       meas_valid;
    logic [9:0] meas_val;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_status;
    logic [3:0] rsp_iters;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cab_prog_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_cab(cmd_cab), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .cmd_target(cmd_target), .cmd_pulse_len(cmd_pulse_len),
        .abort(abort),
        .cab_sel(cab_sel), .row_sel(row_sel), .col_sel(col_sel),
        .sel_en(sel_en), .prog_pulse(prog_pulse), .meas_en(meas_en),
        .meas_valid(meas_valid), .meas_val(meas_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_iters(rsp_iters), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return meas_en;
            1:       return prog_pulse;
            default: return rsp_valid;
        endcase
    endfunction

    // Tick until the selected output is high, with a bounded cycle budget.
    task automatic wait_high(input int sel, input string tag, output int n);
        n = 0;
        while (pick(sel) !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, pick(sel)}, 32'd1);
    endtask

    task automatic send(input logic [2:0] c, input logic [2:0] r, input logic [0:0] col,
                        input logic [9:0] tgt, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_cab = c; cmd_row = r; cmd_col = col;
        cmd_target = tgt; cmd_pulse_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        int hi_cycles;
        int rises;
        int sel_viol;
        logic prev;

        rst = 1'b1; cmd_valid = 1'b0; cmd_cab = 3'd0; cmd_row = 3'd0; cmd_col = 1'b0;
        cmd_target = 10'd0; cmd_pulse_len = 8'd0; abort = 1'b0;
        meas_valid = 1'b0; meas_val = 10'd0; rsp_ready = 1'b0;
        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cab_sel", {25'd0, cab_sel}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: pass on first verify
        send(3'd3, 3'd5, 1'b0, 10'd100, 8'd4);
        chk("t1_cab_sel", {25'd0, cab_sel}, 32'h08);
        chk("t1_row_sel", {29'd0, row_sel}, 32'd5);
        chk("t1_sel_en", {31'd0, sel_en}, 32'd1);
        chk("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_no_pulse_settle", {31'd0, prog_pulse}, 32'd0);
        hi_cycles = 0;
        n = 0;
        while (meas_en !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (prog_pulse === 1'b1) hi_cycles++;
        end
        chk("t1_lat_to_meas", n, 32'd10);
        chk("t1_pulse_cycles", hi_cycles, 32'd4);
        tick(); tick();
        chk("t1_meas_en_hold", {31'd0, meas_en}, 32'd1);
        meas_valid = 1'b1; meas_val = 10'd120;
        tick();
        meas_valid = 1'b0;
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_status", {30'd0, rsp_status}, 32'd0);
        chk("t1_iters", {28'd0, rsp_iters}, 32'd1);
        chk("t1_meas_en_drop", {31'd0, meas_en}, 32'd0);
        chk("t1_resp_sel_en", {31'd0, sel_en}, 32'd0);
        chk("t1_resp_cab_sel", {25'd0, cab_sel}, 32'd0);
        // response accepted with a new command already waiting
        rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_cab = 3'd1; cmd_row = 3'd2;
        cmd_col = 1'b0; cmd_target = 10'd100; cmd_pulse_len = 8'd2;
        tick();
        rsp_ready = 1'b0;
        chk("t1_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_hs_not_accepted", {31'd0, busy}, 32'd0);
        chk("t1_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 2: never reaches target -> timeout after 15 pulses
        tick();
        cmd_valid = 1'b0;
        chk("t2_accepted", {31'd0, busy}, 32'd1);
        chk("t2_cab_sel", {25'd0, cab_sel}, 32'h02);
        meas_valid = 1'b1; meas_val = 10'd50;
        hi_cycles = 0; rises = 0; sel_viol = 0; prev = 1'b0; n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (prog_pulse === 1'b1) hi_cycles++;
            if (prog_pulse === 1'b1 && prev === 1'b0) rises++;
            if (prog_pulse === 1'b1 && sel_en !== 1'b1) sel_viol++;
            prev = prog_pulse;
        end
        meas_valid = 1'b0;
        chk("t2_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        chk("t2_pulses", rises, 32'd15);
        chk("t2_pulse_cycles", hi_cycles, 32'd30);
        chk("t2_pulse_wo_sel", sel_viol, 32'd0);
        chk("t2_status", {30'd0, rsp_status}, 32'd1);
        chk("t2_iters", {28'd0, rsp_iters}, 32'd15);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 3: out-of-range CAB
        send(3'd7, 3'd0, 1'b0, 10'd1, 8'd3);
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_status", {30'd0, rsp_status}, 32'd2);
        chk("t3_iters", {28'd0, rsp_iters}, 32'd0);
        tick();
        chk("t3_cab_sel", {25'd0, cab_sel}, 32'd0);
        chk("t3_sel_en", {31'd0, sel_en}, 32'd0);
        chk("t3_prog_pulse", {31'd0, prog_pulse}, 32'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        // out-of-range column
        send(3'd2, 3'd0, 1'b1, 10'd1, 8'd3);
        chk("t3_col_status", {30'd0, rsp_status}, 32'd2);
        chk("t3_col_sel_en", {31'd0, sel_en}, 32'd0);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 4: abort in 2nd cycle of an 8-cycle pulse
        send(3'd6, 3'd6, 1'b0, 10'd100, 8'd8);
        wait_high(1, "t4_pulse_start", n);
        tick();
        chk("t4_pulse_cycle2", {31'd0, prog_pulse}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_pulse_dropped", {31'd0, prog_pulse}, 32'd0);
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t4_sel_en", {31'd0, sel_en}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t4_hold_status", {30'd0, rsp_status}, 32'd3);
            chk("t4_hold_iters", {28'd0, rsp_iters}, 32'd1);
        end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        chk("t4_back_idle", {31'd0, cmd_ready}, 32'd1);

        // abort ignored while idle
        abort = 1'b1; tick(); abort = 1'b0;
        chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_abort_rsp", {31'd0, rsp_valid}, 32'd0);

        // abort beats a same-cycle passing measurement
        send(3'd0, 3'd1, 1'b0, 10'd100, 8'd1);
        wait_high(0, "t6_meas_en", n);
        meas_valid = 1'b1; meas_val = 10'd200; abort = 1'b1;
        tick();
        meas_valid = 1'b0; abort = 1'b0;
        chk("t6_status", {30'd0, rsp_status}, 32'd3);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

        // 5: zero length gives a one-cycle pulse
        meas_valid = 1'b1; meas_val = 10'd200;
        send(3'd4, 3'd0, 1'b0, 10'd100, 8'd0);
        hi_cycles = 0; n = 0;
        while (rsp_valid !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (prog_pulse === 1'b1) hi_cycles++;
        end
        meas_valid = 1'b0;
        chk("t5_pulse_cycles", hi_cycles, 32'd1);
        chk("t5_status", {30'd0, rsp_status}, 32'd0);
        chk("t5_iters", {28'd0, rsp_iters}, 32'd1);
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        // reset during a pulse
        send(3'd4, 3'd0, 1'b0, 10'd100, 8'd0);
        wait_high(1, "t5_pulse_seen", n);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_pulse", {31'd0, prog_pulse}, 32'd0);
        chk("t5_rst_sel_en", {31'd0, sel_en}, 32'd0);
        chk("t5_rst_cab_sel", {25'd0, cab_sel}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_post_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
